// File: rtl/channel_combinator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : channel_combinator_pkg
//  Description : Types and default constants shared by channel_combinator and
//                channel_select_controller.
//                  sample_t - signed channel sample at the default width
//                  chsel_e  - channel select encoding (0 = c1, 1 = c2)
//  Revision    : 1.0  initial release
// ============================================================================
package channel_combinator_pkg;

    localparam int DEF_DATA_W       = 11;
    localparam int DEF_HI_THRESH    = 960;
    localparam int DEF_LO_THRESH    = 480;
    localparam int DEF_HOLD_SAMPLES = 16;

    typedef logic signed [DEF_DATA_W-1:0] sample_t;

    typedef enum logic {
        CH_C1 = 1'b0,
        CH_C2 = 1'b1
    } chsel_e;

endpackage
`default_nettype wire

// File: rtl/abs_sat.sv
`default_nettype none
// ============================================================================
//  Module      : abs_sat
//  Description : Combinational signed-to-magnitude converter. The most
//                negative input has no positive counterpart in W-1 bits, so
//                it saturates to the largest magnitude.
//  Ports       : din  in  W    signed two's-complement value
//                mag  out W-1  |din|, saturated
//  Revision    : 1.0  initial release
// ============================================================================
module abs_sat #(
    parameter int W = 11
) (
    input  logic signed [W-1:0] din,
    output logic        [W-2:0] mag
);

    logic [W-1:0] neg;

    assign neg = W'(~din) + W'(1);

    always_comb begin
        if (!din[W-1]) begin
            mag = din[W-2:0];
        end else if (neg[W-1]) begin
            // Negation overflowed: input was -2^(W-1).
            mag = '1;
        end else begin
            mag = neg[W-2:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/channel_select_controller.sv
`default_nettype none
// ============================================================================
//  Module      : channel_select_controller
//  Description : Drives the select input of channel_combinator. Switches to
//                the low-gain channel (c2) as soon as channel 1 nears full
//                scale, and returns to c1 only after HOLD_SAMPLES consecutive
//                quiet samples. A level override forces either channel.
//  Ports       : clk          in   system clock
//                reset        in   asynchronous reset, active low
//                enable_3M    in   one-clk sample strobe
//                data_c1      in   channel 1 sample (decides switching)
//                data_c2      in   channel 2 sample (not used in decisions)
//                force_en     in   override enable (level)
//                force_sel    in   override value, 0 = c1, 1 = c2
//                select       out  registered channel select, 0 = c1
//                switch_pulse out  one-clk pulse after every select change
//                in_release   out  release counter is nonzero
//  Revision    : 1.0  initial release
// ============================================================================
module channel_select_controller
    import channel_combinator_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int HI_THRESH    = DEF_HI_THRESH,
    parameter int LO_THRESH    = DEF_LO_THRESH,
    parameter int HOLD_SAMPLES = DEF_HOLD_SAMPLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_3M,
    input  logic [DATA_W-1:0] data_c1,
    input  logic [DATA_W-1:0] data_c2,
    input  logic              force_en,
    input  logic              force_sel,
    output logic              select,
    output logic              switch_pulse,
    output logic              in_release
);

    localparam int MAG_W = DATA_W - 1;
    localparam int CNT_W = $clog2(HOLD_SAMPLES + 1);

    localparam logic [MAG_W-1:0] HI_MAG   = MAG_W'(HI_THRESH);
    localparam logic [MAG_W-1:0] LO_MAG   = MAG_W'(LO_THRESH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_SAMPLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HOLD_SAMPLES);

    typedef enum logic {
        S_C1 = 1'b0,
        S_C2 = 1'b1
    } state_e;

    state_e            state;
    state_e            next_state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  next_cnt;
    logic [MAG_W-1:0]  mag;

    // data_c2 travels alongside data_c1 only for alignment with the combinator.
    logic unused_c2;
    assign unused_c2 = ^data_c2;

    abs_sat #(
        .W   (DATA_W)
    ) u_abs_sat (
        .din (data_c1),
        .mag (mag)
    );

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        if (force_en) begin
            // Override takes priority over a coincident strobe.
            next_state = force_sel ? S_C2 : S_C1;
            next_cnt   = '0;
        end else if (enable_3M) begin
            case (state)
                S_C1: begin
                    if (mag >= HI_MAG) begin
                        next_state = S_C2;
                        next_cnt   = '0;
                    end
                end
                S_C2: begin
                    if (mag >= LO_MAG) begin
                        next_cnt = '0;
                    end else if (cnt == CNT_LAST) begin
                        next_state = S_C1;
                        next_cnt   = '0;
                    end else if (cnt != CNT_MAX) begin
                        next_cnt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    next_state = S_C1;
                    next_cnt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_C1;
            cnt          <= '0;
            switch_pulse <= 1'b0;
        end else begin
            state        <= next_state;
            cnt          <= next_cnt;
            switch_pulse <= (next_state != state);
        end
    end

    assign select     = (state == S_C2) ? CH_C2 : CH_C1;
    assign in_release = (cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_channel_select_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_channel_select_controller
//  Description : Self-checking bench for channel_select_controller. Every
//                driven clock pushes the expected {select, switch_pulse,
//                in_release} from a behavioural model into a scoreboard;
//                each scenario also carries hand-written checkpoints.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_channel_select_controller;
    import channel_combinator_pkg::*;

    logic    clk       = 1'b0;
    logic    reset     = 1'b0;
    logic    enable_3M = 1'b0;
    logic    force_en  = 1'b0;
    logic    force_sel = 1'b0;
    sample_t data_c1   = '0;
    sample_t data_c2   = '0;
    logic    select;
    logic    switch_pulse;
    logic    in_release;

    always #5 clk = ~clk;

    channel_select_controller #(
        .DATA_W       (11),
        .HI_THRESH    (960),
        .LO_THRESH    (480),
        .HOLD_SAMPLES (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable_3M    (enable_3M),
        .data_c1      (data_c1),
        .data_c2      (data_c2),
        .force_en     (force_en),
        .force_sel    (force_sel),
        .select       (select),
        .switch_pulse (switch_pulse),
        .in_release   (in_release)
    );

    typedef struct {
        logic en;
        int   d;
        logic fe;
        logic fs;
        logic chk;
        logic want_sel;
        int   want_pulses;
    } stim_t;

    stim_t      stim_q[$];
    logic [2:0] sb[$];
    int         checks   = 0;
    int         failures = 0;
    logic       m_state  = 1'b0;
    int         m_cnt    = 0;

    function automatic void add_cycles(logic en, int d, int n, logic fe, logic fs);
        stim_t s;
        for (int i = 0; i < n; i++) begin
            s.en = en; s.d = d; s.fe = fe; s.fs = fs;
            s.chk = 1'b0; s.want_sel = 1'b0; s.want_pulses = 0;
            stim_q.push_back(s);
        end
    endfunction

    // One 3 MHz sample = 7 idle clks followed by a strobe clk.
    function automatic void add_samples(int d, int n, logic fe, logic fs);
        for (int i = 0; i < n; i++) begin
            add_cycles(1'b0, d, 7, fe, fs);
            add_cycles(1'b1, d, 1, fe, fs);
        end
    endfunction

    // Hand expectation after the last queued clk: select value and number of
    // switch pulses seen since the previous checkpoint.
    function automatic void mark(logic ws, int wp);
        stim_q[stim_q.size()-1].chk         = 1'b1;
        stim_q[stim_q.size()-1].want_sel    = ws;
        stim_q[stim_q.size()-1].want_pulses = wp;
    endfunction

    task automatic cyc(input stim_t s);
        int   mag;
        logic old;
        enable_3M = s.en;
        data_c1   = sample_t'(s.d);
        data_c2   = sample_t'(s.d >>> 1);
        force_en  = s.fe;
        force_sel = s.fs;
        mag = (s.d < 0) ? -s.d : s.d;
        if (mag > 1023) mag = 1023;
        old = m_state;
        if (s.fe) begin
            m_state = s.fs;
            m_cnt   = 0;
        end else if (s.en) begin
            if (m_state == 1'b0) begin
                if (mag >= 960) begin m_state = 1'b1; m_cnt = 0; end
            end else if (mag >= 480) begin
                m_cnt = 0;
            end else if (m_cnt == 15) begin
                m_state = 1'b0; m_cnt = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        sb.push_back({m_state, m_state != old, m_cnt != 0});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t s; logic [2:0] exp; int npulse = 0;
        checks++;
        if ({select, switch_pulse, in_release} !== 3'b000) begin
            failures++;
            $display("FAIL reset_initial got=%b expected=000", {select, switch_pulse, in_release});
        end
        reset = 1'b1;
        add_samples(1000, 1, 1'b0, 1'b0);
        add_samples(0, 5, 1'b0, 1'b0);
        mark(1'b1, 1);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            cyc(s);
            exp = sb.pop_front();
            checks++;
            if ({select, switch_pulse, in_release} !== exp) begin
                failures++;
                $display("FAIL reset_sb t=%0t got=%b expected=%b", $time, {select, switch_pulse, in_release}, exp);
            end
            if (switch_pulse === 1'b1) npulse++;
            if (s.chk) begin
                checks++;
                if (select !== s.want_sel || npulse != s.want_pulses) begin
                    failures++;
                    $display("FAIL reset_point t=%0t select=%b pulses=%0d expected select=%b pulses=%0d", $time, select, npulse, s.want_sel, s.want_pulses);
                end
                npulse = 0;
            end
        end
        checks++;
        if (in_release !== 1'b1 || dut.cnt !== 5'd5) begin
            failures++;
            $display("FAIL reset_setup in_release=%b cnt=%0d expected 1 and 5", in_release, dut.cnt);
        end
        // Mid-cycle assertion: outputs must clear without waiting for an edge.
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({select, switch_pulse, in_release} !== 3'b000) begin
            failures++;
            $display("FAIL reset_async got=%b expected=000", {select, switch_pulse, in_release});
        end
        m_state = 1'b0;
        m_cnt   = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        add_samples(0, 3, 1'b0, 1'b0);
        mark(1'b0, 0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            cyc(s);
            exp = sb.pop_front();
            checks++;
            if ({select, switch_pulse, in_release} !== exp) begin
                failures++;
                $display("FAIL reset_post_sb t=%0t got=%b expected=%b", $time, {select, switch_pulse, in_release}, exp);
            end
            if (switch_pulse === 1'b1) npulse++;
            if (s.chk) begin
                checks++;
                if (select !== s.want_sel || npulse != s.want_pulses) begin
                    failures++;
                    $display("FAIL reset_post_point t=%0t select=%b pulses=%0d expected select=%b pulses=%0d", $time, select, npulse, s.want_sel, s.want_pulses);
                end
                npulse = 0;
            end
        end
    endtask

    task automatic test_attack();
        stim_t s; logic [2:0] exp; int npulse = 0;
        add_samples(959, 3, 1'b0, 1'b0);  mark(1'b0, 0);
        add_samples(960, 1, 1'b0, 1'b0);  mark(1'b1, 1);  // strobe clk just passed
        add_cycles(1'b0, 0, 1, 1'b0, 1'b0); mark(1'b1, 0); // pulse lasted one clk
        add_cycles(1'b0, 0, 6, 1'b0, 1'b0); mark(1'b1, 0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            cyc(s);
            exp = sb.pop_front();
            checks++;
            if ({select, switch_pulse, in_release} !== exp) begin
                failures++;
                $display("FAIL attack_sb t=%0t got=%b expected=%b", $time, {select, switch_pulse, in_release}, exp);
            end
            if (switch_pulse === 1'b1) npulse++;
            if (s.chk) begin
                checks++;
                if (select !== s.want_sel || npulse != s.want_pulses) begin
                    failures++;
                    $display("FAIL attack_point t=%0t select=%b pulses=%0d expected select=%b pulses=%0d", $time, select, npulse, s.want_sel, s.want_pulses);
                end
                npulse = 0;
            end
        end
    endtask

    task automatic test_neg_sat();
        stim_t s; logic [2:0] exp; int npulse = 0;
        add_samples(0, 16, 1'b0, 1'b0);     mark(1'b0, 1);
        add_samples(-1024, 1, 1'b0, 1'b0);  mark(1'b1, 1);
        add_samples(0, 16, 1'b0, 1'b0);     mark(1'b0, 1);
        add_samples(-959, 4, 1'b0, 1'b0);   mark(1'b0, 0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            cyc(s);
            exp = sb.pop_front();
            checks++;
            if ({select, switch_pulse, in_release} !== exp) begin
                failures++;
                $display("FAIL negsat_sb t=%0t got=%b expected=%b", $time, {select, switch_pulse, in_release}, exp);
            end
            if (switch_pulse === 1'b1) npulse++;
            if (s.chk) begin
                checks++;
                if (select !== s.want_sel || npulse != s.want_pulses) begin
                    failures++;
                    $display("FAIL negsat_point t=%0t select=%b pulses=%0d expected select=%b pulses=%0d", $time, select, npulse, s.want_sel, s.want_pulses);
                end
                npulse = 0;
            end
        end
    endtask

    task automatic test_release();
        stim_t s; logic [2:0] exp; int npulse = 0;
        add_samples(1000, 1, 1'b0, 1'b0);  mark(1'b1, 1);
        add_samples(100, 15, 1'b0, 1'b0);  mark(1'b1, 0);
        add_samples(480, 1, 1'b0, 1'b0);   mark(1'b1, 0);  // not quiet: counter clears
        add_samples(100, 15, 1'b0, 1'b0);  mark(1'b1, 0);
        add_samples(100, 1, 1'b0, 1'b0);   mark(1'b0, 1);
        add_cycles(1'b0, 100, 4, 1'b0, 1'b0); mark(1'b0, 0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            cyc(s);
            exp = sb.pop_front();
            checks++;
            if ({select, switch_pulse, in_release} !== exp) begin
                failures++;
                $display("FAIL release_sb t=%0t got=%b expected=%b", $time, {select, switch_pulse, in_release}, exp);
            end
            if (switch_pulse === 1'b1) npulse++;
            if (s.chk) begin
                checks++;
                if (select !== s.want_sel || npulse != s.want_pulses) begin
                    failures++;
                    $display("FAIL release_point t=%0t select=%b pulses=%0d expected select=%b pulses=%0d", $time, select, npulse, s.want_sel, s.want_pulses);
                end
                npulse = 0;
            end
        end
    endtask

    task automatic test_override();
        stim_t s; logic [2:0] exp; int npulse = 0;
        add_cycles(1'b0, 0, 3, 1'b0, 1'b0);     mark(1'b0, 0);
        add_cycles(1'b0, 0, 1, 1'b1, 1'b1);     mark(1'b1, 1);  // between strobes
        add_samples(0, 40, 1'b1, 1'b1);         mark(1'b1, 0);
        add_samples(0, 15, 1'b0, 1'b0);         mark(1'b1, 0);
        add_samples(0, 1, 1'b0, 1'b0);          mark(1'b0, 1);
        add_cycles(1'b0, 0, 4, 1'b1, 1'b0);     mark(1'b0, 0);  // forced to current value
        add_samples(1023, 2, 1'b1, 1'b0);       mark(1'b0, 0);  // force beats strobe
        add_cycles(1'b0, 0, 2, 1'b0, 1'b0);     mark(1'b0, 0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            cyc(s);
            exp = sb.pop_front();
            checks++;
            if ({select, switch_pulse, in_release} !== exp) begin
                failures++;
                $display("FAIL override_sb t=%0t got=%b expected=%b", $time, {select, switch_pulse, in_release}, exp);
            end
            if (switch_pulse === 1'b1) npulse++;
            if (s.chk) begin
                checks++;
                if (select !== s.want_sel || npulse != s.want_pulses) begin
                    failures++;
                    $display("FAIL override_point t=%0t select=%b pulses=%0d expected select=%b pulses=%0d", $time, select, npulse, s.want_sel, s.want_pulses);
                end
                npulse = 0;
            end
        end
    endtask

    task automatic test_gating();
        stim_t s; logic [2:0] exp; int npulse = 0;
        for (int i = 0; i < 64; i++) add_cycles(1'b0, (i % 2 == 1) ? 1023 : 0, 1, 1'b0, 1'b0);
        mark(1'b0, 0);
        add_samples(1000, 1, 1'b0, 1'b0);        mark(1'b1, 1);
        add_cycles(1'b0, 0, 200, 1'b0, 1'b0);    mark(1'b1, 0);  // quiet, but no strobes
        add_samples(0, 16, 1'b0, 1'b0);          mark(1'b0, 1);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            cyc(s);
            exp = sb.pop_front();
            checks++;
            if ({select, switch_pulse, in_release} !== exp) begin
                failures++;
                $display("FAIL gating_sb t=%0t got=%b expected=%b", $time, {select, switch_pulse, in_release}, exp);
            end
            if (switch_pulse === 1'b1) npulse++;
            if (s.chk) begin
                checks++;
                if (select !== s.want_sel || npulse != s.want_pulses) begin
                    failures++;
                    $display("FAIL gating_point t=%0t select=%b pulses=%0d expected select=%b pulses=%0d", $time, select, npulse, s.want_sel, s.want_pulses);
                end
                npulse = 0;
            end
        end
    endtask

    // Strobe held high: every high clk is a sample.
    task automatic test_back_to_back();
        stim_t s; logic [2:0] exp; int npulse = 0;
        add_cycles(1'b1, 1000, 1, 1'b0, 1'b0);  mark(1'b1, 1);
        add_cycles(1'b1, 0, 15, 1'b0, 1'b0);    mark(1'b1, 0);
        add_cycles(1'b1, 0, 1, 1'b0, 1'b0);     mark(1'b0, 1);
        add_cycles(1'b0, 0, 3, 1'b0, 1'b0);     mark(1'b0, 0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            cyc(s);
            exp = sb.pop_front();
            checks++;
            if ({select, switch_pulse, in_release} !== exp) begin
                failures++;
                $display("FAIL b2b_sb t=%0t got=%b expected=%b", $time, {select, switch_pulse, in_release}, exp);
            end
            if (switch_pulse === 1'b1) npulse++;
            if (s.chk) begin
                checks++;
                if (select !== s.want_sel || npulse != s.want_pulses) begin
                    failures++;
                    $display("FAIL b2b_point t=%0t select=%b pulses=%0d expected select=%b pulses=%0d", $time, select, npulse, s.want_sel, s.want_pulses);
                end
                npulse = 0;
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_attack();
        test_neg_sat();
        test_release();
        test_override();
        test_gating();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
